// File: rtl/hwpe_ctrl_iter_seq.sv
// rtl/hwpe_ctrl_iter_seq.sv - two-level (outer, inner, offset) index sequencer with valid/ready output
module hwpe_ctrl_iter_seq #(
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned OFFSET_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [CNT_WIDTH-1:0]    len_inner_i,
    input  logic [CNT_WIDTH-1:0]    len_outer_i,
    input  logic [OFFSET_WIDTH-1:0] stride_inner_i,
    input  logic [OFFSET_WIDTH-1:0] stride_outer_i,
    output logic                    idx_valid_o,
    input  logic                    idx_ready_i,
    output logic [CNT_WIDTH-1:0]    inner_idx_o,
    output logic [CNT_WIDTH-1:0]    outer_idx_o,
    output logic [OFFSET_WIDTH-1:0] offset_o,
    output logic                    last_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    evt_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    len_inner_q, len_inner_d;
    logic [CNT_WIDTH-1:0]    len_outer_q, len_outer_d;
    logic [OFFSET_WIDTH-1:0] stride_inner_q, stride_inner_d;
    logic [OFFSET_WIDTH-1:0] stride_outer_q, stride_outer_d;
    logic [CNT_WIDTH-1:0]    inner_q, inner_d;
    logic [CNT_WIDTH-1:0]    outer_q, outer_d;
    logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
    logic [OFFSET_WIDTH-1:0] row_base_q, row_base_d;
    logic                    evt_q, evt_d;

    logic inner_end, outer_end, handshake;

    assign inner_end = (inner_q == (len_inner_q - CNT_WIDTH'(1)));
    assign outer_end = (outer_q == (len_outer_q - CNT_WIDTH'(1)));
    assign handshake = (state_q == RUN) && idx_ready_i;

    always_comb begin
        state_d        = state_q;
        len_inner_d    = len_inner_q;
        len_outer_d    = len_outer_q;
        stride_inner_d = stride_inner_q;
        stride_outer_d = stride_outer_q;
        inner_d        = inner_q;
        outer_d        = outer_q;
        offset_d       = offset_q;
        row_base_d     = row_base_q;
        evt_d          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_inner_d    = len_inner_i;
                    len_outer_d    = len_outer_i;
                    stride_inner_d = stride_inner_i;
                    stride_outer_d = stride_outer_i;
                    inner_d        = '0;
                    outer_d        = '0;
                    offset_d       = '0;
                    row_base_d     = '0;
                    if (len_inner_i == '0 || len_outer_i == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (handshake) begin
                    if (!inner_end) begin
                        inner_d  = inner_q + CNT_WIDTH'(1);
                        offset_d = offset_q + stride_inner_q;
                    end else begin
                        evt_d = 1'b1;
                        if (outer_end) begin
                            state_d = DONE;
                        end else begin
                            // Row start offsets come from the row base so inner strides never accumulate across rows.
                            inner_d    = '0;
                            outer_d    = outer_q + CNT_WIDTH'(1);
                            row_base_d = row_base_q + stride_outer_q;
                            offset_d   = row_base_q + stride_outer_q;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear_i) begin
            state_d        = IDLE;
            len_inner_d    = '0;
            len_outer_d    = '0;
            stride_inner_d = '0;
            stride_outer_d = '0;
            inner_d        = '0;
            outer_d        = '0;
            offset_d       = '0;
            row_base_d     = '0;
            evt_d          = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            len_inner_q    <= '0;
            len_outer_q    <= '0;
            stride_inner_q <= '0;
            stride_outer_q <= '0;
            inner_q        <= '0;
            outer_q        <= '0;
            offset_q       <= '0;
            row_base_q     <= '0;
            evt_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_inner_q    <= len_inner_d;
            len_outer_q    <= len_outer_d;
            stride_inner_q <= stride_inner_d;
            stride_outer_q <= stride_outer_d;
            inner_q        <= inner_d;
            outer_q        <= outer_d;
            offset_q       <= offset_d;
            row_base_q     <= row_base_d;
            evt_q          <= evt_d;
        end
    end

    assign idx_valid_o = (state_q == RUN);
    assign inner_idx_o = inner_q;
    assign outer_idx_o = outer_q;
    assign offset_o    = offset_q;
    assign last_o      = (state_q == RUN) && inner_end && outer_end;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign evt_o       = evt_q;

endmodule

// File: tb/tb_hwpe_ctrl_iter_seq.sv
// tb/tb_hwpe_ctrl_iter_seq.sv - directed self-checking bench for hwpe_ctrl_iter_seq
module tb_hwpe_ctrl_iter_seq;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        start;
    logic [15:0] len_inner;
    logic [15:0] len_outer;
    logic [31:0] stride_inner;
    logic [31:0] stride_outer;
    logic        valid;
    logic        ready;
    logic [15:0] inner_idx;
    logic [15:0] outer_idx;
    logic [31:0] offset;
    logic        last;
    logic        busy;
    logic        done;
    logic        evt;

    int          errors;
    int          checks;
    int          hs;
    int          dn;
    int          ev;
    int          pi;
    logic [31:0] exp_off [6];

    hwpe_ctrl_iter_seq #(.CNT_WIDTH(16), .OFFSET_WIDTH(32)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .start_i       (start),
        .len_inner_i   (len_inner),
        .len_outer_i   (len_outer),
        .stride_inner_i(stride_inner),
        .stride_outer_i(stride_outer),
        .idx_valid_o   (valid),
        .idx_ready_i   (ready),
        .inner_idx_o   (inner_idx),
        .outer_idx_o   (outer_idx),
        .offset_o      (offset),
        .last_o        (last),
        .busy_o        (busy),
        .done_o        (done),
        .evt_o         (evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] li, input logic [15:0] lo,
                          input logic [31:0] si, input logic [31:0] so);
        len_inner    = li;
        len_outer    = lo;
        stride_inner = si;
        stride_outer = so;
        start        = 1'b1;
        step();
        start        = 1'b0;
    endtask

    initial begin
        clk = 0; rst_n = 0; clear = 0; start = 0; ready = 0;
        len_inner = 0; len_outer = 0; stride_inner = 0; stride_outer = 0;
        errors = 0; checks = 0;
        exp_off = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h108};

        repeat (2) step();
        chk("rst_valid", valid, 0);
        chk("rst_inner", inner_idx, 0);
        chk("rst_outer", outer_idx, 0);
        chk("rst_offset", offset, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_evt", evt, 0);
        rst_n = 1;
        step();

        // basic 2x3 run, ready held high
        ready = 1;
        launch(16'd3, 16'd2, 32'd4, 32'h100);
        for (int k = 1; k <= 6; k++) begin
            chk("basic_valid", valid, 1);
            chk("basic_busy", busy, 1);
            chk("basic_offset", offset, exp_off[k-1]);
            chk("basic_inner", inner_idx, (k-1) % 3);
            chk("basic_outer", outer_idx, (k-1) / 3);
            chk("basic_last", last, (k == 6));
            chk("basic_evt", evt, (k == 4));
            chk("basic_done", done, 0);
            step();
        end
        chk("basic_done7", done, 1);
        chk("basic_evt7", evt, 1);
        chk("basic_valid7", valid, 0);
        chk("basic_busy7", busy, 1);
        step();
        chk("basic_done8", done, 0);
        chk("basic_busy8", busy, 0);
        chk("basic_evt8", evt, 0);

        // backpressure with ready pattern 1,0,0
        hs = 0; pi = 0;
        launch(16'd3, 16'd2, 32'd4, 32'h100);
        for (int c = 0; c < 40 && hs < 6; c++) begin
            ready = (pi % 3 == 0);
            pi++;
            chk("bp_valid", valid, 1);
            chk("bp_done", done, 0);
            chk("bp_offset", offset, exp_off[hs]);
            chk("bp_inner", inner_idx, hs % 3);
            chk("bp_outer", outer_idx, hs / 3);
            if (ready) hs++;
            step();
        end
        chk("bp_handshakes", hs, 6);
        chk("bp_done_after", done, 1);
        chk("bp_valid_after", valid, 0);
        step();
        chk("bp_done_once", done, 0);
        ready = 1;
        step();

        // zero inner length
        launch(16'd0, 16'd5, 32'd4, 32'h100);
        chk("zero_done", done, 1);
        chk("zero_valid", valid, 0);
        chk("zero_evt", evt, 0);
        chk("zero_busy", busy, 1);
        step();
        chk("zero_done2", done, 0);
        chk("zero_valid2", valid, 0);
        chk("zero_evt2", evt, 0);
        chk("zero_busy2", busy, 0);
        step();

        // restart ignored while running
        hs = 0; dn = 0; ev = 0;
        launch(16'd3, 16'd2, 32'd4, 32'h100);
        for (int c = 1; c <= 12; c++) begin
            if (c == 3) begin
                start = 1; len_inner = 16'd7; len_outer = 16'd7;
            end
            if (valid && ready) hs++;
            if (done) dn++;
            if (evt) ev++;
            step();
            start = 0;
        end
        chk("ign_tuples", hs, 6);
        chk("ign_dones", dn, 1);
        chk("ign_evts", ev, 2);

        // clear mid-run on a 4x4 job
        launch(16'd4, 16'd4, 32'd1, 32'd16);
        step();
        step();
        clear = 1;
        chk("clr_pre_valid", valid, 1);
        chk("clr_pre_inner", inner_idx, 2);
        step();
        clear = 0;
        chk("clr_valid", valid, 0);
        chk("clr_busy", busy, 0);
        chk("clr_inner", inner_idx, 0);
        chk("clr_outer", outer_idx, 0);
        chk("clr_offset", offset, 0);
        chk("clr_done", done, 0);
        chk("clr_evt", evt, 0);
        step();
        launch(16'd4, 16'd4, 32'd1, 32'd16);
        chk("clr_re_valid", valid, 1);
        chk("clr_re_inner", inner_idx, 0);
        chk("clr_re_outer", outer_idx, 0);
        chk("clr_re_offset", offset, 0);
        hs = 0; dn = 0;
        for (int c = 0; c < 30; c++) begin
            if (valid && ready) begin
                if (hs == 5) chk("clr_row1_offset", offset, 32'd17);
                hs++;
            end
            if (done) dn++;
            step();
        end
        chk("clr_re_tuples", hs, 16);
        chk("clr_re_dones", dn, 1);

        // negative inner stride wraps
        launch(16'd3, 16'd1, 32'hFFFF_FFFC, 32'd0);
        chk("wrap_off0", offset, 32'h0);
        chk("wrap_last0", last, 0);
        step();
        chk("wrap_off1", offset, 32'hFFFF_FFFC);
        step();
        chk("wrap_off2", offset, 32'hFFFF_FFF8);
        chk("wrap_last2", last, 1);
        step();
        chk("wrap_done", done, 1);
        chk("wrap_evt", evt, 1);
        chk("wrap_valid", valid, 0);
        step();
        chk("wrap_done_once", done, 0);

        // asynchronous reset mid-job
        launch(16'd3, 16'd2, 32'd4, 32'h100);
        step();
        #2 rst_n = 0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_inner", inner_idx, 0);
        chk("arst_offset", offset, 0);
        rst_n = 1;
        step();
        chk("arst_post_busy", busy, 0);
        chk("arst_post_done", done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hwpe_ctrl_iter_seq.md
# hwpe_ctrl_iter_seq

Two-level iteration sequencer that sits directly downstream of the HWPE control slave. A one-cycle start pulse from the slave's flags launches it, and it reads loop lengths and strides from the register file. It then issues a stream of (outer, inner, offset) index tuples to the datapath over a valid/ready handshake. When the last tuple has been accepted it returns a one-cycle done pulse to the slave's done input, plus per-row event pulses to the slave's event input.

## Interface
- CNT_WIDTH, 16, width of loop lengths and index outputs
- OFFSET_WIDTH, 32, width of strides and offset output
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- clear_i  input  1  synchronous soft clear; connects to the slave's clear output
- start_i  input  1  one-cycle launch pulse; connects to the slave's start flag
- len_inner_i  input  CNT_WIDTH  inner loop length; sampled on an accepted start
- len_outer_i  input  CNT_WIDTH  outer loop length; sampled on an accepted start
- stride_inner_i  input  OFFSET_WIDTH  offset increment per inner step; sampled on an accepted start
- stride_outer_i  input  OFFSET_WIDTH  offset increment per outer step; sampled on an accepted start
- idx_valid_o  output  1  tuple valid
- idx_ready_i  input  1  datapath accepts tuple
- inner_idx_o  output  CNT_WIDTH  current inner index
- outer_idx_o  output  CNT_WIDTH  current outer index
- offset_o  output  OFFSET_WIDTH  current offset
- last_o  output  1  current tuple is the final one
- busy_o  output  1  high whenever the sequencer is not in IDLE
- done_o  output  1  one-cycle completion pulse
- evt_o  output  1  one-cycle end-of-row pulse

## Operation
- FSM states are IDLE, RUN and DONE. Reset and clear both force IDLE.
- IDLE:
  - On start_i, latch both lengths and both strides, and zero both indices and the offset.
  - If either length is 0, go to DONE.
  - Otherwise go to RUN.
  - Any other input leaves the FSM in IDLE.
- RUN:
  - idx_valid_o=1.
  - inner_idx_o, outer_idx_o, offset_o and last_o stay stable until a handshake (idx_valid_o & idx_ready_i).
  - On a handshake that is not the last inner step of a row: inner+1, offset+=stride_inner.
  - On a handshake that is the last inner step of a row (inner==len_inner-1) but not the final tuple: inner=0, outer+1. Offset becomes (outer+1)*stride_outer, held in a separate row-base register that adds stride_outer at each row end.
  - On the final handshake (outer==len_outer-1 and inner==len_inner-1): go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- last_o = RUN & (inner==len_inner-1) & (outer==len_outer-1).
- evt_o is registered. It goes high the cycle after each handshake that ends a row, including the final row, so the final evt_o coincides with done_o.
- start_i is ignored in RUN and DONE: no relatch, no second done.
- Offset arithmetic:
  - Unsigned, modulo 2^OFFSET_WIDTH; wrap-around is silent.
  - Strides are used as two's-complement bit patterns, so negative strides work by wrapping.
- Index counters never exceed length-1. Length 2^CNT_WIDTH-1 is the maximum.
- clear_i has priority over every other input:
  - In any state it returns the FSM to IDLE and zeros all outputs and internal registers.
  - A clear during RUN produces no done_o and no evt_o.
  - clear_i and start_i together: clear wins and the start is dropped.
- Changing len/stride inputs while busy has no effect; only the values latched at start are used.

## Timing
- Reset values: idx_valid_o=0, inner_idx_o=0, outer_idx_o=0, offset_o=0, last_o=0, busy_o=0, done_o=0, evt_o=0.
- All outputs are driven from registers or from the state register with no input-to-output combinational path. Exception: none. In particular, idx_valid_o does not depend on idx_ready_i.
- Start pulse in cycle 0:
  - Nonzero lengths: idx_valid_o=1 and the first tuple (0,0,0) are presented in cycle 1; busy_o=1 from cycle 1.
  - A zero length: done_o=1 in cycle 1 with no tuple issued.
- Throughput: one tuple per cycle while idx_ready_i is held high. A len_outer×len_inner job with ready held high from cycle 1 completes its final handshake in cycle len_outer*len_inner, with done_o in the following cycle.
- Final handshake in cycle t: idx_valid_o=0 in cycle t+1, done_o=1 and busy_o=1 in cycle t+1, busy_o=0 in cycle t+2. Earliest next accepted start is cycle t+2.
- idx_ready_i low stalls indefinitely with no timeout.
- Reset asserted mid-job: all outputs go to their reset values asynchronously, and the job is lost.

## Test plan
- Basic run:
  - Stimulus: len_inner=3, len_outer=2, stride_inner=4, stride_outer=0x100, ready always 1, start in cycle 0.
  - Required response: offsets 0,4,8,0x100,0x104,0x108 in cycles 1-6; last_o only in cycle 6; evt_o in cycles 4 and 7; done_o in cycle 7 only.
- Backpressure:
  - Stimulus: same job, with idx_ready_i toggling 1,0,0,1,...
  - Required response: each tuple is held stable while ready=0, the sequence is identical to the basic run, and done_o follows the 6th handshake by 1 cycle.
- Zero length:
  - Stimulus: len_inner=0, len_outer=5, start in cycle 0.
  - Required response: idx_valid_o never rises, done_o=1 in cycle 1 only, evt_o stays 0.
- Ignored start:
  - Stimulus: start re-pulsed in cycle 3 of a 2×3 job, with the len inputs changed to 7 at the same time.
  - Required response: still exactly 6 tuples and exactly one done_o.
- Clear mid-run:
  - Stimulus: clear_i asserted in cycle 3 of a 4×4 job.
  - Required response: from cycle 4, idx_valid_o=0, busy_o=0 and all indices are 0, with no done_o. A fresh start in cycle 5 begins again from tuple (0,0,0).
- Wrap and negative stride:
  - Stimulus: stride_inner=0xFFFFFFFC (-4), len_inner=3, len_outer=1.
  - Required response: offsets 0, 0xFFFFFFFC, 0xFFFFFFF8; done_o one cycle after the third handshake.
